// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and default sizes for the instruction-memory load controller.
//   imem_state_e : port-ownership phase (CLEAR -> LOAD -> RUN)
//   IMEM_ADDR_W  : default word-address width (DEPTH = 2**IMEM_ADDR_W)
//   IMEM_DATA_W  : default instruction word width
package imem_load_ctrl_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } imem_state_e;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Streaming boot-loader channel (valid/ready with end-of-program marker).
//   valid : loader word present
//   data  : instruction word
//   last  : qualifies the final word of the program
//   ready : controller accepts the word this cycle
//   master modport : boot loader side
//   slave  modport : imem_load_ctrl side
interface imem_load_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/imem_load_ctrl.sv
// Owns the single port of the instruction memory.
// After reset the memory is zero-filled (CLEAR), a program is streamed in from
// the boot loader (LOAD), then the port is handed to CPU fetch (RUN). In RUN a
// debug read may steal a cycle, but never two in a row, so fetch keeps moving.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   ld                  loader stream (slave side of imem_load_ctrl_if)
//   i_reload            pulse in RUN: restart CLEAR/LOAD
//   i_cpu_addr          fetch address      -> o_cpu_rdata, o_cpu_stall
//   i_dbg_req/addr      debug read request -> o_dbg_gnt, o_dbg_rdata
//   o_mem_we/addr/wdata memory port, i_mem_rdata combinational read of o_mem_addr
//   o_load_done         level, state is RUN
//   o_word_count        words accepted by the last load (ADDR_W+1 bits)
//   o_err_overflow      sticky: loader filled the memory without ld_last
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W   = IMEM_ADDR_W,
    parameter int DATA_W   = IMEM_DATA_W,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    imem_load_ctrl_if.slave   ld,
    input  logic              i_reload,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_stall,
    input  logic              i_dbg_req,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic              o_dbg_gnt,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_load_done,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_err_overflow
);

    localparam imem_state_e     START_ST = CLEAR_EN ? CLEAR : LOAD;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

    imem_state_e       r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] r_ld_ptr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_err_overflow;
    logic              r_dbg_turn;     // 1: the cycle after a grant belongs to fetch

    imem_state_e       w_next;
    logic              w_hs;
    logic              w_ld_ready;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_stall;
    logic              w_gnt;
    logic              w_done;

    // Next state and the single port mux. Everything is forced to its idle
    // value while i_rst is high so nothing leaks out during reset.
    always_comb begin
        w_next      = r_state;
        w_hs        = 1'b0;
        w_ld_ready  = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = i_cpu_addr;
        w_mem_wdata = '0;
        w_stall     = 1'b1;
        w_gnt       = 1'b0;
        w_done      = 1'b0;
        if (!i_rst) begin
            case (r_state)
                CLEAR: begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_clr_cnt;
                    if (r_clr_cnt == '1) w_next = LOAD;
                end
                LOAD: begin
                    w_ld_ready = 1'b1;
                    w_mem_addr = r_ld_ptr;
                    if (ld.valid) begin
                        w_hs        = 1'b1;
                        w_mem_we    = 1'b1;
                        w_mem_wdata = ld.data;
                        // Last word, or the memory is full: either way loading ends.
                        if (ld.last || r_ld_ptr == '1) w_next = RUN;
                    end
                end
                RUN: begin
                    w_done  = 1'b1;
                    w_stall = 1'b0;
                    if (i_dbg_req && !r_dbg_turn) begin
                        w_gnt      = 1'b1;
                        w_stall    = 1'b1;
                        w_mem_addr = i_dbg_addr;
                    end
                    if (i_reload) w_next = START_ST;
                end
                default: w_next = START_ST;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= START_ST;
            r_clr_cnt      <= '0;
            r_ld_ptr       <= '0;
            r_word_count   <= '0;
            r_err_overflow <= 1'b0;
            r_dbg_turn     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                CLEAR: r_clr_cnt <= r_clr_cnt + PTR_ONE;
                LOAD: begin
                    if (w_hs) begin
                        r_ld_ptr <= r_ld_ptr + PTR_ONE;
                        if (ld.last) begin
                            r_word_count <= {1'b0, r_ld_ptr} + WC_ONE;
                        end else if (r_ld_ptr == '1) begin
                            r_err_overflow <= 1'b1;
                            r_word_count   <= DEPTH_W;
                        end
                    end
                end
                RUN: begin
                    // A grant hands the next cycle to fetch; otherwise debug is eligible.
                    r_dbg_turn <= w_gnt;
                    if (i_reload) begin
                        r_ld_ptr       <= '0;
                        r_clr_cnt      <= '0;
                        r_err_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (r_state != RUN) r_dbg_turn <= 1'b0;
        end
    end

    assign ld.ready       = w_ld_ready;
    assign o_mem_we       = w_mem_we;
    assign o_mem_addr     = w_mem_addr;
    assign o_mem_wdata    = w_mem_wdata;
    assign o_cpu_rdata    = i_mem_rdata;
    assign o_cpu_stall    = w_stall;
    assign o_dbg_gnt      = w_gnt;
    assign o_dbg_rdata    = i_mem_rdata;
    assign o_load_done    = w_done;
    assign o_word_count   = r_word_count;
    assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized scoreboard bench for imem_load_ctrl. Stimulus pushes expected
// memory writes, fetch data and debug data into queues; a negedge monitor pops
// and compares whenever the DUT writes, fetches unstalled or grants debug.
// Expected memory contents come from a plain array updated by the load rules.
module tb_imem_load_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst;
    logic          reload;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          load_done;
    logic [AW:0]   word_count;
    logic          err_overflow;
    logic          scramble;

    imem_load_ctrl_if #(.DATA_W(DW)) ld_if ();

    imem_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_EN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .ld(ld_if), .i_reload(reload),
        .i_cpu_addr(cpu_addr), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .o_dbg_gnt(dbg_gnt), .o_dbg_rdata(dbg_rdata),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_load_done(load_done), .o_word_count(word_count), .o_err_overflow(err_overflow)
    );

    // Memory array model; garbage-filled during the first reset so CLEAR matters.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [39:0]   wq[$];     // {addr, data} expected writes in order
    logic [DW-1:0] fq[$];     // expected fetch data
    logic [DW-1:0] dq[$];     // expected debug read data
    int            ld_idx;
    logic          prev_gnt = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_chk++;
        $display("FAIL %s: got 0x%0h, want none", name, act);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [39:0] e;
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) fail_now("wr_unexpected", {mem_addr, mem_wdata});
            else begin
                e = wq.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e[39:32]));
                chk("wr_data", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
        if (dbg_gnt === 1'b1) begin
            if (dq.size() == 0) fail_now("dbg_unexpected_gnt", 64'(dbg_addr));
            else chk("dbg_rdata", 64'(dbg_rdata), 64'(dq.pop_front()));
        end
        if (load_done === 1'b1 && cpu_stall === 1'b0 && fq.size() > 0)
            chk("fetch_rdata", 64'(cpu_rdata), 64'(fq.pop_front()));
        if (load_done === 1'b1) begin
            chk("run_stall_eq_gnt", 64'(cpu_stall), 64'(dbg_gnt));
            if (dbg_gnt === 1'b1 && prev_gnt === 1'b1) fail_now("dbg_back_to_back", 64'(dbg_addr));
        end
        prev_gnt <= dbg_gnt;
    end

    task automatic push_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            wq.push_back({8'(i), 32'h0});
        end
        ld_idx = 0;
    endtask

    // Counts CLEAR cycles until ld_ready rises; start = cycles already observed.
    task automatic wait_clear(input int start);
        int cyc  = start;
        bit seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            if (ld_if.ready === 1'b1) seen = 1'b1;
            else cyc++;
        end
        chk("clear_cycles", 64'(cyc), 64'(DEPTH));
        chk("clear_writes_left", 64'(wq.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; reload = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        chk("rst_ld_ready", 64'(ld_if.ready), 64'(0));
        chk("rst_mem_we",   64'(mem_we),      64'(0));
        chk("rst_stall",    64'(cpu_stall),   64'(1));
        chk("rst_dbg_gnt",  64'(dbg_gnt),     64'(0));
        chk("rst_done",     64'(load_done),   64'(0));
        ld_if.valid = 1'b0; ld_if.last = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_word_count", 64'(word_count),   64'(0));
        chk("rst_err",        64'(err_overflow), 64'(0));
        @(posedge clk); #1;
        push_clear();
        scramble = 1'b0;
        rst = 1'b0;
        wait_clear(0);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit exp_acc, input int gap);
        bit acc = 1'b0;
        ld_if.valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        ld_if.valid = 1'b1; ld_if.data = d; ld_if.last = last;
        if (exp_acc) begin
            wq.push_back({8'(ld_idx), d});
            ref_mem[ld_idx] = d;
            ld_idx++;
        end
        for (int t = 0; t < 8 && !acc; t++) begin
            @(negedge clk);
            acc = (ld_if.ready === 1'b1);
            @(posedge clk); #1;
        end
        ld_if.valid = 1'b0; ld_if.last = 1'b0;
        chk("ld_accept", 64'(acc), 64'(exp_acc));
    endtask

    task automatic check_loaded(input int wc, input bit err);
        @(negedge clk);
        chk("load_done",    64'(load_done),    64'(1));
        chk("word_count",   64'(word_count),   64'(wc));
        chk("err_overflow", 64'(err_overflow), 64'(err));
        chk("run_ld_ready", 64'(ld_if.ready),  64'(0));
        @(posedge clk); #1;
    endtask

    task automatic run_random(input int cycles);
        logic [AW-1:0] a;
        for (int c = 0; c < cycles; c++) begin
            if (fq.size() == 0) begin
                a = 8'($urandom);
                cpu_addr = a;
                fq.push_back(ref_mem[a]);
            end
            if (dq.size() == 0) begin
                if ($urandom_range(0, 2) != 0) begin
                    a = 8'($urandom);
                    dbg_req = 1'b1; dbg_addr = a;
                    dq.push_back(ref_mem[a]);
                end else dbg_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int t = 0; t < 8 && (fq.size() > 0 || dq.size() > 0); t++) begin
            if (dq.size() == 0) dbg_req = 1'b0;
            @(posedge clk); #1;
        end
        dbg_req = 1'b0;
        chk("drain_fetch", 64'(fq.size()), 64'(0));
        chk("drain_dbg",   64'(dq.size()), 64'(0));
        fq.delete(); dq.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; scramble = 1'b1; reload = 1'b0;
        cpu_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
        ld_if.valid = 1'b0; ld_if.data = '0; ld_if.last = 1'b0;
        ld_idx = 0;
        @(posedge clk); #1;

        // Reset and full zero-fill
        do_reset();

        // Three-word program with a valid gap after word 1
        send_word(32'hAC41_0000, 1'b0, 1'b1, 0);
        send_word(32'h8C85_0000, 1'b0, 1'b1, 0);
        send_word(32'h10A1_0001, 1'b1, 1'b1, 2);
        check_loaded(3, 1'b0);

        // Zero-latency fetch
        cpu_addr = 8'd2;
        @(negedge clk);
        chk("fetch_addr2", 64'(cpu_rdata), 64'h10A1_0001);
        chk("fetch_addr2_stall", 64'(cpu_stall), 64'(0));
        @(posedge clk); #1;

        // Held debug request: grants every other cycle
        dbg_req = 1'b1; dbg_addr = 8'd1;
        dq.push_back(ref_mem[1]); dq.push_back(ref_mem[1]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dbg_gnt_pattern", 64'(dbg_gnt), 64'((i % 2) == 0));
            chk("dbg_stall_pattern", 64'(cpu_stall), 64'((i % 2) == 0));
            @(posedge clk); #1;
        end
        dbg_req = 1'b0;
        run_random(150);

        // Overflow: 257 words without ld_last
        do_reset();
        for (int k = 0; k < DEPTH; k++) send_word(DW'($urandom), 1'b0, 1'b1, 0);
        send_word(32'hDEAD_BEEF, 1'b0, 1'b0, 0);
        check_loaded(DEPTH, 1'b1);
        run_random(80);

        // Reload from RUN
        reload = 1'b1;
        push_clear();
        @(negedge clk);
        chk("reload_same_cycle_stall", 64'(cpu_stall), 64'(0));
        @(posedge clk); #1;
        reload = 1'b0;
        @(negedge clk);
        chk("reload_next_stall", 64'(cpu_stall),    64'(1));
        chk("reload_err_clear",  64'(err_overflow), 64'(0));
        chk("reload_done_low",   64'(load_done),    64'(0));
        wait_clear(1);

        // Reset while word 10 is on the loader: nothing written, restart from 0
        for (int k = 0; k < 10; k++) send_word(DW'($urandom), 1'b0, 1'b1, $urandom_range(0, 2));
        ld_if.valid = 1'b1; ld_if.data = 32'h1234_5678; ld_if.last = 1'b0;
        do_reset();

        // Random program with gaps
        n = $urandom_range(1, 60);
        for (int k = 0; k < n; k++)
            send_word(DW'($urandom), (k == n - 1), 1'b1, $urandom_range(0, 3));
        check_loaded(n, 1'b0);
        run_random(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
